// File: rtl/csr_timer_bank.sv
// rtl/csr_timer_bank.sv - multi-channel CSR constant timer bank with sticky overrun flags
// Shared prescaler is built only when TIMER_PRESCALE_EN is defined.
module csr_timer_bank #(
  parameter int          NUM_TIMERS   = 2,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [13:0] CSR_BASE     = 14'h040,
  parameter int          PRESCALE_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [13:0]           csr_num,
  input  logic                  csr_re,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic                  cnt_halt,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  timer_int_any
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [13:0]          WIN_SIZE = 14'(8 * NUM_TIMERS);

  logic [13:0] offset;
  logic        in_window;
  logic [2:0]  chan_sel;
  logic [2:0]  reg_sel;
  logic        tick;
  logic [31:0] rd_word [NUM_TIMERS];

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset    = csr_num - CSR_BASE;
  assign chan_sel  = offset[5:3];
  assign reg_sel   = offset[2:0];
  assign in_window = (offset < WIN_SIZE) && (reg_sel < 3'd3);

`ifdef TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PRE_W-1:0] pre_q;

  assign tick = (pre_q == PRE_W'(PRESCALE_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (!cnt_halt) begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
    logic                 hit;
    logic                 wr_cfg;
    logic                 clr_sts;
    logic                 clr_ovf;
    logic                 run;
    logic                 fire;
    logic [CNT_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] cfg_merged;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 sts_q;
    logic                 ovf_q;

    assign hit        = csr_we && in_window && (chan_sel == 3'(n));
    assign wr_cfg     = hit && (reg_sel == 3'd0);
    assign clr_sts    = hit && (reg_sel == 3'd2) && csr_wmask[0] && csr_wvalue[0];
    assign clr_ovf    = hit && (reg_sel == 3'd2) && csr_wmask[1] && csr_wvalue[1];
    assign cfg_merged = (csr_wmask[CNT_WIDTH-1:0] & csr_wvalue[CNT_WIDTH-1:0]) |
                        (~csr_wmask[CNT_WIDTH-1:0] & cfg_q);

    // A config write owns its edge: it reloads (EN=1) or freezes (EN=0), never counts.
    assign run  = !wr_cfg && cfg_q[0] && tick && !cnt_halt;
    assign fire = run && (cnt_q == '0);

    always_comb begin
      cnt_d = cnt_q;
      if (wr_cfg && cfg_merged[0]) begin
        cnt_d = {cfg_merged[CNT_WIDTH-1:2], 2'b00};
      end else if (run && (cnt_q != CNT_ONES)) begin
        if ((cnt_q == '0) && cfg_q[1]) begin
          cnt_d = {cfg_q[CNT_WIDTH-1:2], 2'b00};
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cfg_q <= '0;
        cnt_q <= CNT_ONES;
        sts_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        if (wr_cfg) begin
          cfg_q <= cfg_merged;
        end
        cnt_q <= cnt_d;
        // A fire landing on the same edge as a TICLR clear keeps the flag set.
        if (fire) begin
          sts_q <= 1'b1;
        end else if (clr_sts) begin
          sts_q <= 1'b0;
        end
        if (fire && sts_q) begin
          ovf_q <= 1'b1;
        end else if (clr_ovf) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign timer_int[n] = sts_q;
    assign rd_word[n]   = (reg_sel == 3'd0) ? 32'(cfg_q) :
                          (reg_sel == 3'd1) ? 32'(cnt_q) :
                                              {30'b0, ovf_q, 1'b0};
  end

  always_comb begin
    csr_rvalue = '0;
    if (csr_re && in_window) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (chan_sel == 3'(n)) begin
          csr_rvalue = rd_word[n];
        end
      end
    end
  end

  assign timer_int_any = |timer_int;

endmodule

// File: doc/csr_timer_bank.md
# csr_timer_bank

Parametrised multi-channel constant-timer block that extends the single TCFG/TVAL/TICLR timer in the CSR file to NUM_TIMERS independent channels with configurable counter width, a global halt, a sticky per-channel overrun flag and an optional shared prescaler. It sits beside the CSR register file in the WB-stage CSR path. It decodes its own CSR window and returns read data on a shared bus. Its level interrupt outputs feed ESTAT.IS.

## Interface
- NUM_TIMERS, 2: channel count, 1..8.
- CNT_WIDTH, 32: counter width, 8..32; INITVAL occupies TCFG[CNT_WIDTH-1:2].
- CSR_BASE, 14'h040: window base; channel n registers at CSR_BASE+8n+{0: TCFG, 1: TVAL, 2: TICLR}.
- PRESCALE_DIV, 4: prescaler ratio, ≥1; used only with TIMER_PRESCALE_EN.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- csr_num  in  14  CSR address.
- csr_re  in  1  read enable.
- csr_rvalue  out  32  read data; combinational; 0 when csr_re=0 or the address is outside the window.
- csr_we  in  1  write enable.
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- cnt_halt  in  1  freezes all counters and the prescaler (debug halt).
- timer_int  out  NUM_TIMERS  per-channel interrupt status, registered level.
- timer_int_any  out  1  OR of timer_int.

## Operation
- Write merge: every written field takes new = wmask&wvalue | ~wmask&old.
- TCFG[n]: bit0 EN, bit1 PERIODIC, [CNT_WIDTH-1:2] INITVAL. Bits ≥ CNT_WIDTH are not stored and read 0.
- TVAL[n] is read-only. It returns cnt[n] zero-extended. Writes to it are ignored.
- TICLR[n]:
  - Writing bit0=1 (masked) clears the status.
  - Writing bit1=1 (masked) clears OVF.
  - Reads return {30'b0, OVF, 1'b0}.
- Counter per channel, checked in priority order each edge:
  1. TCFG write with merged EN=1: load cnt={merged INITVAL, 2'b0}.
  2. Else if EN && tick && !cnt_halt && cnt != all-ones: if cnt==0 && PERIODIC, load {INITVAL, 2'b0}; otherwise decrement.
  3. Otherwise hold.
- Terminal count: cnt reaches 0 in one-shot mode, then decrements to all-ones and stops there.
- Fire event: EN && tick && !cnt_halt && cnt==0 && no TCFG load this edge.
  - A fire event sets the status.
  - A fire event while the status is already 1 also sets OVF.
- Simultaneous fire and TICLR clear: set wins for both status and OVF.
- Writing EN=0 freezes cnt at its current value. The status is not cleared.
- Channels are fully independent; one write addresses one channel only.
- Reset values: EN=0, PERIODIC=0, INITVAL=0, cnt=all-ones, status=0, OVF=0. Consequently timer_int=0 and timer_int_any=0.

## Timing
- Register writes take effect at the sampling edge. Read-back of the new value is available in the next cycle.
- timer_int follows the status register directly; there is no extra delay stage.
- With tick always 1 and INITVAL=k after a TCFG write at edge e:
  - cnt=4k after e.
  - cnt=0 after edge e+4k.
  - The status rises after edge e+4k+1.
  - At that same edge cnt reloads to 4k (periodic) or becomes all-ones (one-shot).
- INITVAL=0 with EN=1: cnt=0 after the load, and fires on the next counting edge.
- A TCFG write on the same edge as a fire condition loads the counter and suppresses the fire.
- cnt_halt high holds the counter, status and prescaler exactly. Pending CSR writes still complete.
- Reset asserted mid-count immediately returns every channel to its reset values.

## Configuration
- TIMER_PRESCALE_EN defined:
  - A shared prescaler counts unhalted cycles from 0 up to PRESCALE_DIV-1, then wraps.
  - tick=1 only on the wrap cycle, so counters decrement once per PRESCALE_DIV cycles.
  - The prescaler resets to 0.
  - TCFG loads remain immediate, independent of tick.
- TIMER_PRESCALE_EN undefined: tick is tied to 1, PRESCALE_DIV is ignored, and no prescaler logic is built.

## Test plan
- Reset, then read TVAL0 → 32'hFFFF_FFFF. timer_int=0. TCFG0 reads 0.
- Write TCFG0=0x5 (INITVAL=1, one-shot, EN) → TVAL0 reads 4,3,2,1,0 on successive cycles. timer_int[0] rises 5 edges after the write. TVAL0 then reads FFFF_FFFF and stays there.
- Write TCFG1=0x7 (periodic, INITVAL=1) → timer_int[1]=1 after the first expiry. Without a clear, the second expiry sets TICLR1 read value to 0x2 (OVF). Write TICLR1=0x3 → reads 0x0 and timer_int[1]=0.
- TICLR clear issued on the same edge as a fire → status remains 1.
- Assert cnt_halt for 10 cycles mid-count → TVAL unchanged throughout, and counting resumes from the held value.
- With TIMER_PRESCALE_EN and PRESCALE_DIV=4, write TCFG0=0x5 → each TVAL step lasts 4 cycles, and the fire occurs about 20 cycles after the write.
